mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single synchronous memory port (32-bit data, 16-bit address) between the CPU and a second bus master, such as a program loader or DMA engine. Each requester uses a req/ack handshake. The block grants one transaction at a time, registers address, write data and write-enable onto the memory bus, and returns read data with a one-cycle ack pulse. It sits between the masters and the memory, in place of the direct CPU-to-memory wiring.

## Interface
- DATA_W, 32, data bus width
- ADDR_W, 16, address bus width
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- r0_req  in  1  requester 0 (CPU) transaction request
- r0_we  in  1  requester 0 write (1) / read (0)
- r0_addr  in  ADDR_W  requester 0 address
- r0_wdata  in  DATA_W  requester 0 write data
- r0_ack  out  1  requester 0 completion pulse
- r0_rdata  out  DATA_W  requester 0 read data
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata: same as requester 0, for requester 1
- mem_addr  out  ADDR_W  memory address (drives memory address input)
- mem_wdata  out  DATA_W  memory write data
- mem_write  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, registered by the memory, valid the cycle after the address is presented

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any req is high: pick a winner, latch its we/addr/wdata into output registers, set owner, go to ACCESS.
  - If no req is high: stay in IDLE.
- **ACCESS**
  - mem_addr and mem_wdata carry the latched values.
  - mem_write equals the latched we; it is high for exactly this one cycle.
  - Next state: RESP.
- **RESP**
  - Pulse the owner's ack for one cycle.
  - On a read, the owner's rdata is updated from mem_rdata at the ACCESS→RESP edge and is valid while ack is high.
  - mem_write = 0.
  - Next state: IDLE, always.
- **Arbitration**
  - Round-robin over two requesters, using last_grant.
  - On a tie, the requester not in last_grant wins.
  - A lone requester wins regardless of last_grant.
  - last_grant updates on each grant.
- **Handshake**
  - A requester holds req high until it sees ack, then may drop req or re-request.
  - Changes to addr/we/wdata after the grant edge are ignored, because they are already latched.
  - A req dropped before ack is a protocol violation; the transaction still completes and ack is still pulsed.
- **Read data hold**
  - rN_rdata holds its last read value between transactions.
  - Writes do not change rN_rdata.
  - The non-owner's rdata never changes.

## Timing
- **Reset values**
  - State IDLE; last_grant = 1 (so requester 0 wins the first tie).
  - mem_addr = 0, mem_wdata = 0, mem_write = 0.
  - r0_ack = r1_ack = 0; r0_rdata = r1_rdata = 0.
- **Latency**: req high before edge k (IDLE) → ACCESS during cycle k+1 → ack during cycle k+2.
- **Throughput**: one transaction per 3 cycles; this is the minimum spacing between grants.
- **Memory bus in IDLE and RESP**: mem_write = 0; mem_addr and mem_wdata keep their last values.
- **Reset mid-operation**
  - Reset asserted during ACCESS: the memory still samples the write at that edge, so the write lands. No ack is issued and the FSM goes to IDLE.
  - Reset asserted during RESP: the ack is suppressed from the next cycle on.
- **Simultaneous events**: both reqs high in RESP have no effect until IDLE, where they are arbitrated as a tie.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties, and last_grant is unused. Requester 1 can starve under continuous requester-0 traffic.
- Undefined (default): round-robin as described in Operation.

## Structure
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE, ACCESS, RESP);
  - requester ID constants (REQ_CPU = 0, REQ_AUX = 1);
  - default DATA_W and ADDR_W.
- One sub-module, rr_pick2: combinational 2-way winner selection from req[1:0] and last_grant.
  - Honours MEM_ARB_FIXED_PRIO_EN.
  - Outputs grant_id and grant_valid.

## Test plan
- **Reset**: hold reset 2 cycles with both reqs high → all outputs 0; first grant occurs on the first edge after reset deasserts.
- **Single write then read**
  - r0 writes 0xDEADBEEF to 0x0010 → mem_write high for one cycle with mem_addr = 0x0010, r0_ack 2 cycles after the IDLE edge.
  - r0 then reads 0x0010 → r0_rdata = 0xDEADBEEF while r0_ack is high; r1_rdata unchanged.
- **Tie, round-robin**: both reqs held continuously, each re-requesting after ack → acks alternate r0, r1, r0, r1, spaced 3 cycles apart.
- **Tie, fixed priority** (MEM_ARB_FIXED_PRIO_EN defined): same stimulus → only r0 acked while r0_req is held.
- **Late field change**: r1 changes r1_addr from 0x0100 to 0x0200 one cycle after its grant → memory sees 0x0100.
- **Reset during ACCESS of a write to 0x0020 of 0x12345678**: a later read of 0x0020 returns 0x12345678; no ack is issued for the interrupted transaction.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, requester IDs, default bus widths.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way winner selection for the memory arbiter.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
// Ports: req_i[1:0] requests, last_grant_i previous winner;
//        grant_id_o winner, grant_valid_o any request present.
// Build option: MEM_ARB_FIXED_PRIO_EN makes requester 0 win every tie
// (last_grant_i is then ignored and requester 1 can starve).
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_id_o,
  output logic       grant_valid_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_id_o    = REQ_CPU;
    if (req_i == 2'b10) begin
      grant_id_o = REQ_AUX;
    end else if (req_i == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant_id_o = REQ_CPU;
`else
      // Tie: whoever did not win last time goes next.
      grant_id_o = ~last_grant_i;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between two req/ack masters.
// Latency: grant on the IDLE edge, one ACCESS cycle, ack pulse the cycle after (3 cycles/txn).
// Backpressure: requester holds req until its ack; the loser waits for the next IDLE.
// Ports: clk, reset (sync, active high); rN_req/rN_we/rN_addr/rN_wdata in and
//        rN_ack/rN_rdata out for N=0 (CPU) and N=1 (aux master);
//        mem_addr/mem_wdata/mem_write out to the memory, mem_rdata back from it.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q;
  logic              last_grant_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_write_q;
  logic              r0_ack_q;
  logic              r1_ack_q;
  logic [DATA_W-1:0] r0_rdata_q;
  logic [DATA_W-1:0] r1_rdata_q;

  logic              grant_id;
  logic              grant_vld;
  logic              sel_we_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;

  rr_pick2 u_pick (
    .req_i         ({r1_req, r0_req}),
    .last_grant_i  (last_grant_q),
    .grant_id_o    (grant_id),
    .grant_valid_o (grant_vld)
  );

  // Fields of whichever requester the picker chose this cycle.
  always_comb begin
    sel_we_d    = (grant_id == REQ_AUX) ? r1_we    : r0_we;
    sel_addr_d  = (grant_id == REQ_AUX) ? r1_addr  : r0_addr;
    sel_wdata_d = (grant_id == REQ_AUX) ? r1_wdata : r0_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= REQ_AUX;  // so requester 0 wins the first tie
      owner_q      <= REQ_CPU;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_write_q  <= 1'b0;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
    end else begin
      // Write enable and acks are single-cycle pulses by default.
      mem_write_q <= 1'b0;
      r0_ack_q    <= 1'b0;
      r1_ack_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            owner_q      <= grant_id;
            last_grant_q <= grant_id;
            we_q         <= sel_we_d;
            mem_addr_q   <= sel_addr_d;
            mem_wdata_q  <= sel_wdata_d;
            mem_write_q  <= sel_we_d;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          // Read data is captured only into the owner's register, and only on reads.
          if (owner_q == REQ_AUX) begin
            r1_ack_q <= 1'b1;
            if (!we_q) r1_rdata_q <= mem_rdata;
          end else begin
            r0_ack_q <= 1'b1;
            if (!we_q) r0_rdata_q <= mem_rdata;
          end
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;
  assign r0_ack    = r0_ack_q;
  assign r1_ack    = r1_ack_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized two-master run for mem_arbiter.
// Latency: n/a (testbench).
// Backpressure: masters hold req until ack, as a real master would.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rq    [2];
  logic          rwe   [2];
  logic [AW-1:0] raddr [2];
  logic [DW-1:0] rwd   [2];
  logic          r0_ack, r1_ack, mem_write;
  logic [DW-1:0] r0_rdata, r1_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  // Memory model: small word array, write on the clock edge, read data
  // presented for whatever address is on the bus.
  logic [DW-1:0] phys [1024];
  logic          mem_clr;

  int   checks = 0;
  int   errors = 0;
  logic model_last;          // requester granted most recently
  logic [DW-1:0] exp_rd [2]; // expected held read data per requester

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) phys[i] <= '0;
    end else if (mem_write) begin
      phys[mem_addr[9:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = phys[mem_addr[9:0]];

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .r0_req    (rq[0]),
    .r0_we     (rwe[0]),
    .r0_addr   (raddr[0]),
    .r0_wdata  (rwd[0]),
    .r0_ack    (r0_ack),
    .r0_rdata  (r0_rdata),
    .r1_req    (rq[1]),
    .r1_we     (rwe[1]),
    .r1_addr   (raddr[1]),
    .r1_wdata  (rwd[1]),
    .r1_ack    (r1_ack),
    .r1_rdata  (r1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // Advance past the next rising edge; outputs are sampled and inputs driven here.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic new_txn(input int i);
    rq[i]    = 1'b1;
    rwe[i]   = 1'($urandom_range(0, 1));
    raddr[i] = 16'h0040 + 16'($urandom_range(0, 7));
    rwd[i]   = $urandom;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_clr = 1'b1;
    rq[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 16'h0005; rwd[0] = 32'h0000AAAA;
    rq[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 16'h0007; rwd[1] = 32'h0;
    tick;
    mem_clr = 1'b0;
    tick;
    checks++;
    if ({mem_write, r0_ack, r1_ack} !== 3'b000) begin
      errors++; $display("FAIL reset_ctl got %b want 000", {mem_write, r0_ack, r1_ack});
    end
    checks++;
    if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus got addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    checks++;
    if (r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h %h want 0", r0_rdata, r1_rdata);
    end
    reset = 1'b0;
    tick;  // first edge after reset: tie, requester 0 wins
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 16'h0005 || mem_wdata !== 32'h0000AAAA) begin
      errors++; $display("FAIL first_grant got we %b addr %h wdata %h want 1 0005 0000aaaa",
                         mem_write, mem_addr, mem_wdata);
    end
    rq[1] = 1'b0;
    tick;
    checks++;
    if (r0_ack !== 1'b1 || r1_ack !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL first_ack got ack0 %b ack1 %b we %b want 1 0 0", r0_ack, r1_ack, mem_write);
    end
    rq[0] = 1'b0;
    tick;
    model_last = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  task automatic test_write_read;
    rq[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 16'h0010; rwd[0] = 32'hDEADBEEF;
    tick;
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 32'hDEADBEEF || r0_ack !== 1'b0) begin
      errors++; $display("FAIL wr_access got we %b addr %h wdata %h ack %b", mem_write, mem_addr, mem_wdata, r0_ack);
    end
    tick;
    checks++;
    if (r0_ack !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 16'h0010) begin
      errors++; $display("FAIL wr_resp got ack %b we %b addr %h want 1 0 0010", r0_ack, mem_write, mem_addr);
    end
    rq[0] = 1'b0;
    tick;
    rq[0] = 1'b1; rwe[0] = 1'b0; rwd[0] = 32'h0;
    tick;
    checks++;
    if (mem_write !== 1'b0 || mem_addr !== 16'h0010) begin
      errors++; $display("FAIL rd_access got we %b addr %h want 0 0010", mem_write, mem_addr);
    end
    tick;
    checks++;
    if (r0_ack !== 1'b1 || r0_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_resp got ack %b rdata %h want 1 deadbeef", r0_ack, r0_rdata);
    end
    checks++;
    if (r1_rdata !== exp_rd[1]) begin
      errors++; $display("FAIL rd_other got %h want %h", r1_rdata, exp_rd[1]);
    end
    rq[0] = 1'b0;
    tick;
    checks++;
    if (r0_rdata !== 32'hDEADBEEF || r0_ack !== 1'b0) begin
      errors++; $display("FAIL rd_hold got rdata %h ack %b want deadbeef 0", r0_rdata, r0_ack);
    end
    exp_rd[0] = 32'hDEADBEEF;
    model_last = 1'b0;
  endtask

  task automatic test_tie;
    logic first, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 16'h0010;
    rq[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 16'h0005;
    first = FIXED ? 1'b0 : ~model_last;
    w = first;
    for (int t = 1; t <= 12; t++) begin
      tick;
      w = FIXED ? 1'b0 : (first ^ 1'(((t - 1) / 3) % 2));
      a = w ? 16'h0005 : 16'h0010;
      d = w ? 32'h0000AAAA : 32'hDEADBEEF;
      case ((t - 1) % 3)
        0: begin
          checks++;
          if (mem_write !== 1'b0 || mem_addr !== a) begin
            errors++; $display("FAIL tie_access t%0d got we %b addr %h want 0 %h", t, mem_write, mem_addr, a);
          end
        end
        1: begin
          exp_rd[w] = d;
          checks++;
          if (r0_ack !== (w == 1'b0) || r1_ack !== (w == 1'b1)) begin
            errors++; $display("FAIL tie_ack t%0d got %b%b want winner %0d", t, r1_ack, r0_ack, w);
          end
          checks++;
          if (r0_rdata !== exp_rd[0] || r1_rdata !== exp_rd[1]) begin
            errors++; $display("FAIL tie_rdata t%0d got %h %h want %h %h", t, r0_rdata, r1_rdata, exp_rd[0], exp_rd[1]);
          end
        end
        default: begin
          checks++;
          if (r0_ack !== 1'b0 || r1_ack !== 1'b0) begin
            errors++; $display("FAIL tie_idle t%0d got acks %b%b want 00", t, r1_ack, r0_ack);
          end
        end
      endcase
    end
    rq[0] = 1'b0; rq[1] = 1'b0;
    model_last = w;
    tick;
  endtask

  task automatic test_late_change;
    rq[1] = 1'b1; rwe[1] = 1'b1; raddr[1] = 16'h0100; rwd[1] = 32'h5A5A0001;
    tick;
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 16'h0100) begin
      errors++; $display("FAIL late_grant got we %b addr %h want 1 0100", mem_write, mem_addr);
    end
    raddr[1] = 16'h0200; rwd[1] = 32'hFFFF0000; rwe[1] = 1'b0;
    tick;
    checks++;
    if (mem_addr !== 16'h0100 || mem_wdata !== 32'h5A5A0001 || r1_ack !== 1'b1) begin
      errors++; $display("FAIL late_hold got addr %h wdata %h ack %b want 0100 5a5a0001 1", mem_addr, mem_wdata, r1_ack);
    end
    checks++;
    if (phys[10'h100] !== 32'h5A5A0001 || phys[10'h200] !== 32'h0) begin
      errors++; $display("FAIL late_mem got [100]=%h [200]=%h want 5a5a0001 0", phys[10'h100], phys[10'h200]);
    end
    checks++;
    if (r1_rdata !== exp_rd[1]) begin
      errors++; $display("FAIL late_rdata got %h want %h", r1_rdata, exp_rd[1]);
    end
    rq[1] = 1'b0;
    tick;
    model_last = 1'b1;
  endtask

  task automatic test_reset_access;
    rq[1] = 1'b1; rwe[1] = 1'b1; raddr[1] = 16'h0020; rwd[1] = 32'h12345678;
    tick;
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 16'h0020) begin
      errors++; $display("FAIL rst_acc_grant got we %b addr %h want 1 0020", mem_write, mem_addr);
    end
    reset = 1'b1; rq[1] = 1'b0;
    tick;
    checks++;
    if (r1_ack !== 1'b0 || mem_write !== 1'b0 || r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_acc_state got ack %b we %b rdata %h %h want 0 0 0 0", r1_ack, mem_write, r0_rdata, r1_rdata);
    end
    reset = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    tick;
    checks++;
    if (r1_ack !== 1'b0) begin
      errors++; $display("FAIL rst_acc_noack got %b want 0", r1_ack);
    end
    rq[0] = 1'b1; rwe[0] = 1'b0; raddr[0] = 16'h0020;
    tick;
    tick;
    checks++;
    if (r0_ack !== 1'b1 || r0_rdata !== 32'h12345678) begin
      errors++; $display("FAIL rst_acc_read got ack %b rdata %h want 1 12345678", r0_ack, r0_rdata);
    end
    exp_rd[0] = 32'h12345678;
    rq[0] = 1'b0;
    tick;
    model_last = 1'b0;
  endtask

  // Transaction-level model: the arbiter is free 3 edges after each grant; a
  // grant takes the requests present at that edge, ack follows one edge later.
  task automatic test_random;
    logic [DW-1:0] ref_mem [8];
    int            g_edge;
    logic          g_own, g_we, w, seen, granted;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd;
    logic          ack_exp [2];
    int            gap [2];
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    g_edge = -100; seen = 1'b0;
    g_own = 1'b0; g_we = 1'b0; g_addr = '0; g_wd = '0; w = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0;
      gap[i] = $urandom_range(0, 3);
    end
    for (int e = 0; e < 900; e++) begin
      tick;
      ack_exp[0] = 1'b0; ack_exp[1] = 1'b0;
      if (e == g_edge + 1) begin
        ack_exp[g_own] = 1'b1;
        if (g_we) ref_mem[g_addr[2:0]] = g_wd;
        else      exp_rd[g_own] = ref_mem[g_addr[2:0]];
      end
      granted = 1'b0;
      if (e >= g_edge + 3 && (rq[0] || rq[1])) begin
        if (rq[0] && rq[1]) w = FIXED ? 1'b0 : ~model_last;
        else                w = rq[1];
        g_edge = e; g_own = w; g_we = rwe[w]; g_addr = raddr[w]; g_wd = rwd[w];
        model_last = w; granted = 1'b1; seen = 1'b1;
      end
      checks++;
      if (mem_write !== ((e == g_edge) && g_we)) begin
        errors++; $display("FAIL rnd_we e%0d got %b want %b", e, mem_write, (e == g_edge) && g_we);
      end
      checks++;
      if (r0_ack !== ack_exp[0] || r1_ack !== ack_exp[1]) begin
        errors++; $display("FAIL rnd_ack e%0d got %b%b want %b%b", e, r1_ack, r0_ack, ack_exp[1], ack_exp[0]);
      end
      checks++;
      if (r0_rdata !== exp_rd[0] || r1_rdata !== exp_rd[1]) begin
        errors++; $display("FAIL rnd_rdata e%0d got %h %h want %h %h", e, r0_rdata, r1_rdata, exp_rd[0], exp_rd[1]);
      end
      if (seen) begin
        checks++;
        if (mem_addr !== g_addr || mem_wdata !== g_wd) begin
          errors++; $display("FAIL rnd_bus e%0d got %h %h want %h %h", e, mem_addr, mem_wdata, g_addr, g_wd);
        end
      end
      // Granted requester scrambles its fields; they must already be latched.
      if (granted) begin
        rwe[w]   = 1'($urandom_range(0, 1));
        raddr[w] = 16'h0040 + 16'($urandom_range(0, 7));
        rwd[w]   = $urandom;
      end
      for (int i = 0; i < 2; i++) begin
        if (ack_exp[i]) begin
          if ($urandom_range(0, 1) == 1) new_txn(i);
          else begin rq[i] = 1'b0; gap[i] = $urandom_range(0, 4); end
        end else if (!rq[i]) begin
          if (gap[i] == 0) new_txn(i);
          else gap[i]--;
        end
      end
    end
    rq[0] = 1'b0; rq[1] = 1'b0;
    tick; tick; tick;
  endtask

  initial begin
    mem_clr = 1'b0;
    test_reset;
    test_write_read;
    test_tie;
    test_late_change;
    test_reset_access;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
